// File: rtl/lsm_sequencer_pkg.sv
// Shared constants and state encoding for the load/store-multiple sequencer.
package lsm_sequencer_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int NREG   = 8;

  typedef enum logic [2:0] {IDLE, STORE, LOAD, WB, DONE} state_t;
endpackage

// File: rtl/lsm_sequencer_lsb_find.sv
// Combinational lowest-set-bit finder: index of the lowest set mask bit.
module lsb_find #(
  parameter int NREG  = 8,
  parameter int IDX_W = $clog2(NREG)
) (
  input  logic [NREG-1:0]  mask,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);
  // Scan high to low so the last hit is the lowest set bit.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = NREG-1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: moves masked registers to/from consecutive memory words.
module lsm_sequencer #(
  parameter int ADDR_W = lsm_sequencer_pkg::ADDR_W,
  parameter int DATA_W = lsm_sequencer_pkg::DATA_W,
  parameter int NREG   = lsm_sequencer_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [NREG-1:0]         reg_mask,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREG)-1:0] rf_rd_sel,
  input  logic [DATA_W-1:0]       rf_rd_data,
  output logic                    rf_wr_en,
  output logic [$clog2(NREG)-1:0] rf_wr_sel,
  output logic [DATA_W-1:0]       rf_wr_data,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [DATA_W-1:0]       mem_in,
  output logic                    mem_write,
  output logic                    mem_read,
  input  logic [DATA_W-1:0]       mem_out
);
  import lsm_sequencer_pkg::*;

  localparam int SEL_W = $clog2(NREG);

  state_t            state, state_nxt;
  logic [NREG-1:0]   mask, mask_rest, mask_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [SEL_W-1:0]  idx_cur, idx_nxt;
  logic              vld_cur, vld_nxt;
  logic              wr_en_q, mem_write_q, mem_read_q;

  // idx_cur: register served this cycle; idx_nxt: register served next cycle.
  lsb_find #(.NREG(NREG), .IDX_W(SEL_W)) u_cur (.mask(mask),     .idx(idx_cur), .vld(vld_cur));
  lsb_find #(.NREG(NREG), .IDX_W(SEL_W)) u_nxt (.mask(mask_nxt), .idx(idx_nxt), .vld(vld_nxt));

  assign mask_rest = vld_cur ? (mask & ~(NREG'(1) << idx_cur)) : mask;

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    addr_nxt  = addr;
    case (state)
      IDLE: if (start) begin
        mask_nxt = reg_mask;
        addr_nxt = base_addr;
        if (reg_mask == '0)  state_nxt = DONE;
        else if (is_store)   state_nxt = STORE;
        else                 state_nxt = LOAD;
      end
      STORE: begin
        mask_nxt  = mask_rest;
        addr_nxt  = addr + ADDR_W'(1);
        state_nxt = (|mask_rest) ? STORE : DONE;
      end
      LOAD: state_nxt = WB;
      WB: begin
        mask_nxt  = mask_rest;
        addr_nxt  = addr + ADDR_W'(1);
        state_nxt = (|mask_rest) ? LOAD : DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they align with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mask        <= '0;
      addr        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr_en_q     <= 1'b0;
      mem_write_q <= 1'b1;
      mem_read_q  <= 1'b1;
      mem_address <= '0;
      rf_rd_sel   <= '0;
      rf_wr_sel   <= '0;
      rf_wr_data  <= '0;
    end else begin
      state       <= state_nxt;
      mask        <= mask_nxt;
      addr        <= addr_nxt;
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      wr_en_q     <= (state_nxt == WB);
      mem_write_q <= (state_nxt != STORE);
      mem_read_q  <= (state_nxt != LOAD);
      mem_address <= (state_nxt == STORE || state_nxt == LOAD) ? addr_nxt : '0;
      rf_rd_sel   <= (state_nxt == STORE && vld_nxt) ? idx_nxt : '0;
      rf_wr_sel   <= (state_nxt == WB) ? idx_nxt : '0;
      rf_wr_data  <= (state_nxt == WB) ? mem_out : '0;
    end
  end

  // Reset low squashes side effects within the same cycle, before the flops clear.
  assign rf_wr_en  = wr_en_q & rst_n;
  assign mem_write = mem_write_q | ~rst_n;
  assign mem_read  = mem_read_q | ~rst_n;
  assign mem_in    = (state == STORE && rst_n) ? rf_rd_data : '0;
endmodule

// File: tb/tb_lsm_sequencer.sv
// Scoreboard bench: reference events from mask/base arithmetic, monitor compares DUT activity.
module tb_lsm_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, start, is_store;
  logic [5:0]  base_addr;
  logic [7:0]  reg_mask;
  logic        busy, done, rf_wr_en, mem_write, mem_read;
  logic [2:0]  rf_rd_sel, rf_wr_sel;
  logic [15:0] rf_rd_data, rf_wr_data, mem_in, mem_out;
  logic [5:0]  mem_address;

  always #5 clk = ~clk;

  lsm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .base_addr(base_addr), .reg_mask(reg_mask), .busy(busy), .done(done),
    .rf_rd_sel(rf_rd_sel), .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en),
    .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data), .mem_address(mem_address),
    .mem_in(mem_in), .mem_write(mem_write), .mem_read(mem_read), .mem_out(mem_out)
  );

  // environment: register file and memory
  logic [15:0] rf [8];
  logic [15:0] mem [64];
  logic [15:0] seed_rf [8];
  logic [15:0] seed_mem [64];
  logic        seed_en = 1'b0;

  assign rf_rd_data = rf[rf_rd_sel];

  always @(posedge clk) begin
    if (seed_en) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_mem[i];
      for (int i = 0; i < 8; i++)  rf[i]  <= seed_rf[i];
    end else begin
      if (!mem_write) mem[mem_address] <= mem_in;
      if (rf_wr_en)   rf[rf_wr_sel]    <= rf_wr_data;
    end
  end

  always @(negedge clk) if (!mem_read) mem_out <= mem[mem_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int cyc; int a; int d; } ev_t; // kind 0 mem write, 1 rf write, 2 done
  ev_t q[$];

  int tests = 0, fails = 0;
  bit mon_en = 1'b0;
  int busy_run = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic pop_check(int kind, int a, int d);
    ev_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: kind %0d a %0h d %0h at cycle %0d, none expected", kind, a, d, cyc);
    end else begin
      e = q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_cycle", cyc, e.cyc);
      check("ev_addr", a, e.a);
      check("ev_data", d, e.d);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) busy_run++; else busy_run = 0;
      if (!mem_write) pop_check(0, int'(mem_address), int'(mem_in));
      if (rf_wr_en)   pop_check(1, int'(rf_wr_sel), int'(rf_wr_data));
      if (done)       pop_check(2, 0, busy_run);
      if (!mem_write || !mem_read) check("strobe_excl", {mem_write, mem_read} == 2'b00, 0);
      if (!busy)
        check("idle_outs",
              {mem_write, mem_read, rf_wr_en, mem_address, mem_in, rf_rd_sel, rf_wr_sel, rf_wr_data, done},
              {1'b1, 1'b1, 1'b0, 6'd0, 16'd0, 3'd0, 3'd0, 16'd0, 1'b0});
    end
  end

  // Issue one operation and push its expected event stream; returns in the done cycle.
  task automatic issue(input bit st, input logic [5:0] base, input logic [7:0] m, input bit poke, input int gap);
    int k, n, j;
    ev_t e;
    repeat (gap + 1) begin @(posedge clk); #1; end
    k = cyc;
    n = 0;
    start = 1'b1; is_store = st; base_addr = base; reg_mask = m;
    for (int b = 0; b < 8; b++) begin
      if (m[b]) begin
        e.kind = st ? 0 : 1;
        e.cyc  = st ? k + 1 + n : k + 2 + 2*n;
        e.a    = st ? (int'(base) + n) % 64 : b;
        e.d    = st ? int'(rf[b]) : int'(mem[(int'(base) + n) % 64]);
        q.push_back(e);
        n++;
      end
    end
    e.kind = 2;
    e.cyc  = st ? k + 1 + n : k + 1 + 2*n;
    e.a    = 0;
    e.d    = e.cyc - k;
    q.push_back(e);
    @(posedge clk); #1;
    j = 0;
    while (!done && j < 40) begin
      start     = poke && (cyc == k + 2);
      is_store  = 1'($urandom);
      base_addr = 6'($urandom);
      reg_mask  = 8'($urandom);
      @(posedge clk); #1;
      j++;
    end
    start = 1'b0;
    check("done_timeout", done, 1);
  endtask

  initial begin
    int k;
    logic [5:0]  b;
    logic [15:0] r1_old;
    ev_t e;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = '0; reg_mask = '0;
    for (int i = 0; i < 8; i++)  seed_rf[i]  = 16'($urandom);
    for (int i = 0; i < 64; i++) seed_mem[i] = 16'($urandom);
    seed_rf[0] = 16'hAAAA; seed_rf[2] = 16'h5555;
    seed_mem[62] = 16'd1; seed_mem[63] = 16'd2; seed_mem[0] = 16'd3;
    seed_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    seed_en = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobes", {mem_write, mem_read}, 2'b11);
    check("rst_wr_en", rf_wr_en, 0);
    check("rst_data", {mem_address, mem_in, rf_rd_sel, rf_wr_sel, rf_wr_data}, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    issue(1'b1, 6'd10, 8'b0000_0101, 1'b0, 0);
    check("sm_mem10", mem[10], 16'hAAAA);
    check("sm_mem11", mem[11], 16'h5555);

    issue(1'b0, 6'd62, 8'b1000_0011, 1'b0, 0);
    check("lm_r0", rf[0], 16'd1);
    check("lm_r1", rf[1], 16'd2);
    check("lm_r7", rf[7], 16'd3);

    issue(1'b1, 6'($urandom), 8'h00, 1'b0, 1);
    issue(1'b0, 6'($urandom), 8'h00, 1'b0, 0);
    issue(1'b1, 6'($urandom), 8'hFF, 1'b1, 0);

    // reset during the second WB of an LM with mask 0x0F
    @(posedge clk); #1;
    k = cyc;
    b = 6'($urandom);
    start = 1'b1; is_store = 1'b0; base_addr = b; reg_mask = 8'h0F;
    e.kind = 1; e.cyc = k + 2; e.a = 0; e.d = int'(mem[b]);
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    r1_old = rf[1];
    rst_n = 1'b0;
    #1;
    check("rstwb_wr_en", rf_wr_en, 0);
    check("rstwb_strobes", {mem_write, mem_read}, 2'b11);
    @(posedge clk); #1;
    check("rstwb_busy", busy, 0);
    check("rstwb_done", done, 0);
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("rstwb_r1_kept", rf[1], r1_old);

    repeat (30) begin
      logic [7:0] m;
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      issue(1'($urandom), 6'($urandom), m, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
